// File: rtl/sram_bridge.sv
// sram_bridge: splits one 32-bit LSU access into N = 32/DATA_W SRAM beats.
// Each beat holds the strobes for WAIT_CYC cycles. Writes add one hold cycle
// per beat. The core is stalled while an access is in flight.
// Ports:
//   i_clk, i_rst (async, active-high)
//   core side: i_req, i_wren, i_addr, i_wdata, i_bmask -> o_stall, o_ack, o_rdata
//   sram side: o_sram_addr, o_sram_dq_out/oe, i_sram_dq_in, ce/we/oe/be strobes (active-low)
module sram_bridge #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_wren,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_bmask,
  output logic              o_stall,
  output logic              o_ack,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq_in,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [DATA_W/8-1:0] o_sram_be_n
);
  localparam int N  = 32 / DATA_W;
  localparam int L  = DATA_W / 8;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_dw
    $error("sram_bridge: DATA_W must be 8, 16 or 32");
  end
  if (WAIT_CYC < 1) begin : g_bad_wait
    $error("sram_bridge: WAIT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DONE} state_t;

  state_t          state, nxt_state;
  logic [BW-1:0]   beat_q, nxt_beat, fbeat;
  logic [CW-1:0]   wcnt_q, nxt_wcnt;
  logic            wren_q;
  logic [29:0]     waddr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      bmask_q;

  // In IDLE the request has not been latched yet, so the outputs for the
  // first beat are built straight from the core inputs.
  logic            cur_wren;
  logic [29:0]     cur_waddr;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_mask;
  logic [N-1:0]    act;
  logic [BW:0]     start;
  logic            found;
  logic [31:0]     beat_addr;
  logic            wlast;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_addr[1:0];

  assign o_stall = (state == ACCESS) || (state == HOLD) || (state == IDLE && i_req);
  assign wlast   = (wcnt_q == CW'(WAIT_CYC - 1));

  always_comb begin
    cur_wren  = (state == IDLE) ? i_wren        : wren_q;
    cur_waddr = (state == IDLE) ? i_addr[31:2]  : waddr_q;
    cur_wdata = (state == IDLE) ? i_wdata       : wdata_q;
    cur_mask  = (state == IDLE) ? i_bmask       : bmask_q;
    // reads touch every beat; writes skip beats whose byte enables are all off
    for (int b = 0; b < N; b++) act[b] = !cur_wren || (|cur_mask[b*L +: L]);
    start = (state == IDLE) ? '0 : ({1'b0, beat_q} + 1'b1);
    found = 1'b0;
    fbeat = '0;
    for (int b = N - 1; b >= 0; b--) begin
      if (act[b] && (b >= int'(start))) begin
        found = 1'b1;
        fbeat = BW'(b);
      end
    end

    nxt_state = state;
    nxt_beat  = beat_q;
    nxt_wcnt  = wcnt_q;
    case (state)
      IDLE: if (i_req) begin
        if (found) begin nxt_state = ACCESS; nxt_beat = fbeat; nxt_wcnt = '0; end
        else         nxt_state = DONE;
      end
      ACCESS: begin
        if (!wlast)        nxt_wcnt  = wcnt_q + 1'b1;
        else if (wren_q)   nxt_state = HOLD;
        else if (found)    begin nxt_beat = fbeat; nxt_wcnt = '0; end
        else               nxt_state = DONE;
      end
      HOLD: begin
        if (found) begin nxt_state = ACCESS; nxt_beat = fbeat; nxt_wcnt = '0; end
        else         nxt_state = DONE;
      end
      default: nxt_state = IDLE;
    endcase
    beat_addr = ({2'b00, cur_waddr} * 32'(N)) + 32'(nxt_beat);
  end

  // Strobes are registered from the next state so the pins are glitch-free
  // and have no combinational path from i_req.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      beat_q        <= '0;
      wcnt_q        <= '0;
      wren_q        <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      bmask_q       <= '0;
      o_ack         <= 1'b0;
      o_rdata       <= '0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= '0;
      o_sram_dq_oe  <= 1'b0;
      o_sram_ce_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_be_n   <= '1;
    end else begin
      state  <= nxt_state;
      beat_q <= nxt_beat;
      wcnt_q <= nxt_wcnt;
      if (state == IDLE && i_req) begin
        wren_q  <= i_wren;
        waddr_q <= i_addr[31:2];
        wdata_q <= i_wdata;
        bmask_q <= i_bmask;
      end
      if (state == ACCESS && !wren_q && wlast)
        o_rdata[beat_q*DATA_W +: DATA_W] <= i_sram_dq_in;

      o_ack        <= (nxt_state == DONE);
      o_sram_ce_n  <= !(nxt_state == ACCESS || nxt_state == HOLD);
      o_sram_oe_n  <= !(nxt_state == ACCESS && !cur_wren);
      o_sram_we_n  <= !(nxt_state == ACCESS && cur_wren);
      o_sram_dq_oe <= (nxt_state == ACCESS || nxt_state == HOLD) && cur_wren;
      if (nxt_state == ACCESS) begin
        o_sram_addr <= beat_addr[ADDR_W-1:0];
        o_sram_be_n <= cur_wren ? ~cur_mask[nxt_beat*L +: L] : '0;
        if (cur_wren) o_sram_dq_out <= cur_wdata[nxt_beat*DATA_W +: DATA_W];
      end else if (nxt_state != HOLD) begin
        o_sram_be_n <= '1;
      end
    end
  end
endmodule
